uart_cmd_engine: RTL

//  Parametrised line-oriented command engine between the UART rx/tx byte layer and the clock core.

---
 rtl/uart_cmd_pkg.sv | 52 +++++
 rtl/uart_cmd_engine_if.sv | 27 ++
 rtl/uart_reply_tx.sv | 49 ++++
 rtl/uart_cmd_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: constants shared by the line command engine.
// ASCII codes, FSM states, keyword ROM and reply strings.
package uart_cmd_pkg;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_S  = 8'h73;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_DECODE,
    ST_REPLY
  } state_e;

  localparam int N_KW = 6;
  localparam int KW_W = 8;

  // Index k of the ROM is the bit position of the matching strobe.
  localparam logic [N_KW-1:0][8*KW_W-1:0] KW_ROM = {
    64'("shutdown"),
    64'("exit"),
    64'("setcl"),
    64'("check"),
    64'("reset"),
    64'("start")
  };

  localparam logic [N_KW-1:0][3:0] KW_LEN = {
    4'd8, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5
  };

  localparam logic [23:0] OK_STR  = "OK\n";
  localparam logic [55:0] ERR_STR = "ERROR!\n";

  function automatic logic [2:0] last_idx(input logic is_err);
    return is_err ? 3'd6 : 3'd2;
  endfunction

  function automatic logic [7:0] reply_byte(
    input logic       is_err,
    input logic [2:0] idx
  );
    logic [55:0] s;
    s = is_err ? ERR_STR : {OK_STR, 32'h0};
    s = s << {idx, 3'b000};
    return s[55:48];
  endfunction

endpackage

// File: rtl/uart_cmd_engine_if.sv
// uart_cmd_engine_if: rx byte strobe plus tx valid/ready byte link.
// master = UART byte layer, slave = command engine.
interface uart_cmd_engine_if;

  logic       rx_vld;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_rdy;

  modport master (
    output rx_vld,
    output rx_data,
    output tx_rdy,
    input  tx_data,
    input  tx_vld
  );

  modport slave (
    input  rx_vld,
    input  rx_data,
    input  tx_rdy,
    output tx_data,
    output tx_vld
  );

endinterface

// File: rtl/uart_reply_tx.sv
// uart_reply_tx: streams "OK\n" or "ERROR!\n" over valid/ready.
// load_i restarts a reply; last_o flags acceptance of the final '\n'.
module uart_reply_tx
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       err_i,
  input  logic       active_i,
  input  logic       tx_rdy_i,
  output logic [7:0] tx_data_o,
  output logic       tx_vld_o,
  output logic       last_o
);

  logic       sel_q;
  logic       sel_d;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic       fire;

  assign fire      = active_i & tx_rdy_i;
  assign tx_vld_o  = active_i;
  assign tx_data_o = active_i ? reply_byte(sel_q, idx_q) : 8'h00;
  assign last_o    = fire & (idx_q == last_idx(sel_q));

  always_comb begin
    sel_d = sel_q;
    idx_d = idx_q;
    if (load_i) begin
      sel_d = err_i;
      idx_d = '0;
    end else if (fire && !last_o) begin
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= 1'b0;
      idx_q <= '0;
    end else begin
      sel_q <= sel_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/uart_cmd_engine.sv
// uart_cmd_engine: collects rx bytes into a line, decodes it on '\n'
// into a command strobe or a BCD time load, and replies OK/ERROR.
module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int N_DIGITS = 6,
  parameter int HOUR_MAX = 23,
  parameter int SUB_MAX  = 59
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_cmd_engine_if.slave      bus,
  input  logic                  err_in,
  output logic                  cmd_start,
  output logic                  cmd_reset,
  output logic                  cmd_check,
  output logic                  cmd_setcl,
  output logic                  cmd_exit,
  output logic                  cmd_shutdown,
  output logic                  time_vld,
  output logic [4*N_DIGITS-1:0] time_bcd,
  output logic                  rx_drop
);

  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int TW   = 4 * N_DIGITS;
  localparam int TLEN = N_DIGITS + 2;

  state_e                  state_q;
  state_e                  state_d;
  logic [MAX_LEN-1:0][7:0] buf_q;
  logic [MAX_LEN-1:0][7:0] buf_d;
  logic [LW-1:0]           len_q;
  logic [LW-1:0]           len_d;
  logic                    ovf_q;
  logic                    ovf_d;
  logic                    pend_q;
  logic                    pend_d;
  logic [N_KW-1:0]         cmd_q;
  logic [N_KW-1:0]         cmd_d;
  logic                    tv_q;
  logic                    tv_d;
  logic [TW-1:0]           bcd_q;
  logic [TW-1:0]           bcd_d;
  logic                    drop_q;
  logic                    drop_d;

  logic [N_KW-1:0] kw_hit;
  logic            time_ok;
  logic [TW-1:0]   time_val;
  logic            load;
  logic            load_err;
  logic            last;

  always_comb begin
    logic [8*KW_W-1:0] kw;
    kw = '0;
    for (int k = 0; k < N_KW; k++) begin
      kw = KW_ROM[k] << (8 * (KW_W - int'(KW_LEN[k])));
      kw_hit[k] = (int'(len_q) == int'(KW_LEN[k]));
      for (int i = 0; i < KW_W; i++) begin
        if (i < int'(KW_LEN[k]) &&
            buf_q[i] != kw[8*(KW_W-1-i) +: 8])
          kw_hit[k] = 1'b0;
      end
    end
  end

  if (TLEN <= MAX_LEN) begin : g_time
    always_comb begin
      logic [3:0] d_hi;
      logic [3:0] d_lo;
      logic [6:0] pv;
      d_hi = '0;
      d_lo = '0;
      pv   = '0;
      time_val = '0;
      time_ok = (int'(len_q) == TLEN) &&
                (buf_q[0] == CH_S) &&
                (buf_q[1] == CH_SP);
      for (int i = 0; i < N_DIGITS; i++) begin
        if (buf_q[2+i] < CH_0 || buf_q[2+i] > CH_9)
          time_ok = 1'b0;
        time_val[TW-1-4*i -: 4] = 4'(buf_q[2+i] - CH_0);
      end
      // Pair 0 is hours; every later pair is minutes/seconds.
      for (int p = 0; p < N_DIGITS / 2; p++) begin
        d_hi = time_val[TW-1-8*p -: 4];
        d_lo = time_val[TW-5-8*p -: 4];
        pv   = 7'(d_hi) * 7'd10 + 7'(d_lo);
        if (p == 0) begin
          if (pv > 7'(HOUR_MAX)) time_ok = 1'b0;
        end else begin
          if (pv > 7'(SUB_MAX)) time_ok = 1'b0;
        end
      end
    end
  end else begin : g_no_time
    assign time_ok  = 1'b0;
    assign time_val = '0;
  end

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    pend_d   = pend_q;
    cmd_d    = '0;
    tv_d     = 1'b0;
    bcd_d    = bcd_q;
    drop_d   = 1'b0;
    load     = 1'b0;
    load_err = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin
        if (bus.rx_vld && bus.rx_data == CH_LF) begin
          state_d = ST_DECODE;
        end else if (bus.rx_vld && bus.rx_data != CH_CR) begin
          if (int'(len_q) < MAX_LEN) begin
            for (int i = 0; i < MAX_LEN; i++)
              if (int'(len_q) == i) buf_d[i] = bus.rx_data;
            len_d = len_q + LW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        // The rx byte is accounted for before err_in is judged.
        if (err_in) begin
          if (state_d == ST_COLLECT && len_d == '0) begin
            state_d  = ST_REPLY;
            load     = 1'b1;
            load_err = 1'b1;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        state_d = ST_REPLY;
        load    = 1'b1;
        len_d   = '0;
        ovf_d   = 1'b0;
        if (!ovf_q && |kw_hit) begin
          cmd_d = kw_hit;
        end else if (!ovf_q && time_ok) begin
          tv_d  = 1'b1;
          bcd_d = time_val;
        end else begin
          load_err = 1'b1;
        end
        if (bus.rx_vld) drop_d = 1'b1;
        if (err_in) pend_d = 1'b1;
      end
      ST_REPLY: begin
        if (bus.rx_vld) drop_d = 1'b1;
        if (err_in) pend_d = 1'b1;
        if (last) begin
          if (pend_q || err_in) begin
            pend_d   = 1'b0;
            load     = 1'b1;
            load_err = 1'b1;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      buf_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      cmd_q   <= '0;
      tv_q    <= 1'b0;
      bcd_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      tv_q    <= tv_d;
      bcd_q   <= bcd_d;
      drop_q  <= drop_d;
    end
  end

  uart_reply_tx u_reply (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .err_i    (load_err),
    .active_i (state_q == ST_REPLY),
    .tx_rdy_i (bus.tx_rdy),
    .tx_data_o(bus.tx_data),
    .tx_vld_o (bus.tx_vld),
    .last_o   (last)
  );

  assign cmd_start    = cmd_q[0];
  assign cmd_reset    = cmd_q[1];
  assign cmd_check    = cmd_q[2];
  assign cmd_setcl    = cmd_q[3];
  assign cmd_exit     = cmd_q[4];
  assign cmd_shutdown = cmd_q[5];
  assign time_vld     = tv_q;
  assign time_bcd     = bcd_q;
  assign rx_drop      = drop_q;

endmodule
